// File: rtl/instr_fetch_reg.sv
// Fetch stage and instruction register for the multicycle RISC-V core.
// Owns PC/OldPC/IR and runs the imem request/acknowledge handshake.
module instr_fetch_reg #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_start,
   input  logic        pc_write,
   input  logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] old_pc,
   output logic        instr_valid,
   output logic        busy,
   output logic        misalign,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pend_pc;
   logic        pend_valid;
   logic        redirect_ok;
   logic        redirect_bad;

   // Alignment is judged when the redirect is presented, so a bad target never reaches pc or pend_pc.
   assign redirect_ok  = pc_write && (pc_next[1:0] == 2'b00);
   assign redirect_bad = pc_write && (pc_next[1:0] != 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         IDLE:    if (fetch_start) state_nxt = REQ;
         REQ:     if (imem_ack)    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign imem_req    = (state == REQ);
   assign busy        = (state == REQ);
   assign instr_valid = (state == DONE);
   assign imem_addr   = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         old_pc      <= RESET_PC;
         instr       <= NOP_INSTR;
         pend_pc     <= RESET_PC;
         pend_valid  <= 1'b0;
         misalign    <= 1'b0;
         fetch_count <= '0;
      end else begin
         if (redirect_bad) misalign <= 1'b1;

         if (state == REQ) begin
            if (imem_ack) begin
               instr       <= imem_rdata;
               old_pc      <= pc;
               fetch_count <= fetch_count + 32'd1;
               pend_valid  <= 1'b0;
               // A redirect arriving with the ack is newer than anything pending.
               if (redirect_ok)     pc <= pc_next;
               else if (pend_valid) pc <= pend_pc;
               else                 pc <= pc + 32'd4;
            end else if (redirect_ok) begin
               pend_pc    <= pc_next;
               pend_valid <= 1'b1;
            end
         end else if (redirect_ok) begin
            pc <= pc_next;
         end
      end
   end

endmodule

// File: doc/instr_fetch_reg.md
Name: instr_fetch_reg

Overview:
- Fetch stage and instruction register for the multicycle RISC-V core.
- Owns PC, OldPC and IR, and runs the instruction-memory request/acknowledge handshake.
- Presents the latched instruction to the decoder and to the immediate extender.
- Presents OldPC to the branch/JAL target adder, which computes OldPC + ImmExt. The control unit starts each fetch and redirects the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, IR value on reset (addi x0,x0,0)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
fetch_start  input  1  control unit request to fetch the instruction at pc
pc_write  input  1  control unit PC redirect strobe
pc_next  input  32  redirect target (ALU result / result mux)
imem_req  output  1  instruction memory request, held until ack
imem_addr  output  32  fetch address, equals pc while imem_req=1
imem_rdata  input  32  instruction word, valid when imem_ack=1
imem_ack  input  1  memory acknowledge, one-cycle pulse
instr  output  32  instruction register, feeds decoder and immediate extender
pc  output  32  current PC
old_pc  output  32  address of the instruction held in instr
instr_valid  output  1  one-cycle pulse, high the cycle after IR loads
busy  output  1  high while in REQ state
misalign  output  1  sticky flag: redirect target not word aligned
fetch_count  output  32  count of completed fetches, wraps modulo 2^32

Behaviour:
- Reset (rst_n=0, async, effective immediately, including mid-REQ):
  - pc=RESET_PC, old_pc=RESET_PC, instr=NOP_INSTR.
  - imem_req=0, instr_valid=0, busy=0, misalign=0, fetch_count=0.
  - pending redirect cleared, state=IDLE.
- States: IDLE, REQ, DONE.
- IDLE:
  - fetch_start=1 -> REQ next cycle.
  - pc_write=1 with pc_next[1:0]=00 -> pc<=pc_next.
  - pc_write=1 with pc_next[1:0]!=00 -> pc unchanged, misalign<=1.
  - pc_write and fetch_start in the same cycle: the redirect applies first. The fetch uses the new pc, visible on imem_addr in REQ.
- REQ:
  - imem_req=1, busy=1, imem_addr=pc, all stable until ack.
  - fetch_start is ignored.
  - pc_write is buffered in a one-entry pending register; a later pc_write overwrites it. The alignment check happens at capture, so a misaligned target sets misalign and is not buffered.
  - On imem_ack:
    - instr<=imem_rdata, old_pc<=pc, fetch_count<=fetch_count+1.
    - pc<=pending target if a redirect is pending, else pc+4. The pending register is then cleared.
    - pc_write and imem_ack in the same cycle: the incoming pc_next wins over both pending and pc+4.
    - Go to DONE.
  - Zero-wait memory (ack in the first REQ cycle) is legal: the fetch takes 2 cycles from fetch_start to instr update.
- DONE:
  - instr_valid=1 for exactly this cycle; next state is IDLE.
  - pc_write is handled as in IDLE.
  - fetch_start is ignored. The control unit must re-issue it from IDLE.
- Ack discipline:
  - imem_ack outside REQ is ignored; IR and PC are unchanged.
  - imem_rdata is sampled only on an accepted ack.
- Arithmetic:
  - pc+4 is 32-bit and wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
  - fetch_count wraps from 32'hFFFF_FFFF to 0.
- misalign clears only on reset.
- instr, old_pc and pc hold their values between fetches, so the immediate extender sees a stable instruction through all decode/execute cycles.

Test Plan:
- Reset, then fetch_start with ack after 3 wait cycles and rdata=32'h00500093:
  - imem_req high for 4 cycles with imem_addr=0.
  - Then instr=32'h00500093, old_pc=0, pc=4, instr_valid pulses once, fetch_count=1.
- Zero-wait fetch: ack in the first REQ cycle -> instr updates 2 cycles after fetch_start, busy high for exactly 1 cycle.
- Redirects during REQ:
  - pc_write pc_next=32'h100 during REQ, then ack -> pc=32'h100 (not pc+4), old_pc=old address.
  - pc_write pc_next=32'h200 in the same cycle as ack, with 32'h100 pending -> pc=32'h200.
- Misaligned redirect: pc_write pc_next=32'h102 in IDLE -> pc unchanged, misalign=1, and misalign stays 1 through later fetches.
- Wrap: pc=32'hFFFF_FFFC, fetch with ack -> pc=0, old_pc=32'hFFFF_FFFC. A stray ack in IDLE leaves instr unchanged.
- Reset mid-REQ: rst_n low while imem_req=1 -> imem_req drops asynchronously, pc=RESET_PC, instr=32'h00000013, state IDLE.
